j11bus_arb: RTL and testbench
=============================

Name: j11bus_arb

Overview:
- Two-master arbiter and address decoder for the 22-bit J11 system bus.
- Master 0 is the CPU bus interface; master 1 is a DMA/debug master.
- Each granted transfer is routed to the memory target, the I/O-page target, or answered locally with a nonexistent-memory error.
- A watchdog times out I/O cycles that are never acknowledged, so the CPU always receives an ack (with err) instead of hanging.

Parameters:
- MEMTOP, 22'h200000: first byte address with no memory behind it. Non-I/O addresses >= MEMTOP error locally.
- TIMEOUT, 64: cycles from io_req to forced error ack. Range 2..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  one-cycle request pulse; m0_wr/addr/wdata/wstrb are held stable until m0_ack
- m0_wr  in  1  1 = write
- m0_addr  in  22  byte address
- m0_wdata  in  16  write data
- m0_wstrb  in  2  byte strobes ([1] = high byte)
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  16  read data, valid with m0_ack
- m0_err  out  1  bus error, valid with m0_ack
- m1_*  same set, for master 1
- mem_req  out  1  one-cycle request pulse to memory
- mem_wr  out  1  write enable to memory
- mem_addr  out  22  memory address
- mem_wdata  out  16  memory write data
- mem_wstrb  out  2  memory byte strobes
- mem_ack  in  1  memory completion pulse
- mem_rdata  in  16  memory read data
- io_req  out  1  one-cycle request pulse to I/O page
- io_wr  out  1  write enable to I/O page
- io_addr  out  13  offset within I/O page
- io_wdata  out  16  I/O write data
- io_wstrb  out  2  I/O byte strobes
- io_ack  in  1  I/O completion pulse
- io_rdata  in  16  I/O read data
- io_err  in  1  I/O error, valid with io_ack

Behaviour:
- Reset (rst sampled high):
  - state = IDLE; pend0 = pend1 = 0; last = 1.
  - All outputs 0, including req/ack pulses, addresses, data and strobes.
  - Reset mid-transfer abandons the transfer; no ack is issued for it.
- Pending capture: mX_req sets pendX. pendX clears when port X is granted.
  - A grant may happen in the same cycle as the request: effective request is mX_req | pendX.
  - A second mX_req before mX_ack is a protocol violation and is ignored.
- Arbitration (in IDLE):
  - One effective request: grant it.
  - Both: grant the port != last.
  - last := granted port.
- Decode of the granted address A:
  - IO when A[21:13] == 9'h1FF.
  - Otherwise MEM when A < MEMTOP.
  - Otherwise NXM.
- States:
  - IDLE: on grant, latch the port's fields and go to MEM, IO or NXM.
    - MEM/IO: pulse mem_req/io_req for exactly one cycle, the cycle after grant.
    - Same cycle: drive mem_* or io_* fields (io_addr = A[12:0]); they hold until ack.
  - MEM: wait for mem_ack. No timeout. On ack, latch mem_rdata, err = 0, go to RESP.
  - IO: 8-bit counter, cleared at io_req, increments each cycle.
    - io_ack: latch io_rdata and io_err, go to RESP.
    - Counter == TIMEOUT-1 without io_ack: rdata = 0, err = 1, go to RESP.
    - io_ack and timeout in the same cycle: the ack wins.
  - NXM: one cycle; rdata = 0, err = 1, go to RESP. No downstream request.
  - RESP: pulse mX_ack for one cycle with mX_rdata/mX_err for the owner, return to IDLE.
    - The next grant may occur in the cycle after RESP.
- Other-port outputs:
  - The non-owning port's ack stays 0.
  - Its rdata/err hold their last values.
- Latency:
  - req at cycle 0 -> mem_req at cycle 1.
  - mem_ack at cycle k -> mX_ack at cycle k+1.
  - NXM: ack at cycle 2.
- Stray and ignored inputs:
  - mem_ack/io_ack received outside MEM/IO (including a late ack after timeout) is ignored.
  - Writes: downstream rdata is ignored; mX_rdata is the latched value, don't-care for writes.
- Byte strobes and wr pass through unchanged. No burst, no posting, at most one transfer outstanding.

Test Plan:
- m0 read A=22'h001000, mem_ack at cycle 4 with rdata 16'h1234 -> mem_req at cycle 1 with mem_addr 22'h001000; m0_ack at cycle 5 with rdata 16'h1234, err = 0.
- m0 write A=22'h3FFF70 (I/O page), wdata 16'h00AA, wstrb 2'b01 -> io_req with io_addr 13'h1F70, io_wr = 1, io_wstrb 2'b01; io_ack with io_err = 1 -> m0_ack, m0_err = 1.
- m1 read A=22'h250000 -> no mem_req/io_req; m1_ack at cycle 2, err = 1, rdata = 0.
- m0_req and m1_req in the same cycle, repeated 3 times after reset -> grant order 0,1,0,1,0,1. A second request arriving during a busy transfer waits and is served next.
- m0 I/O read with no io_ack, TIMEOUT = 64 -> m0_ack with err = 1, rdata = 0, 64 cycles after io_req. Then an io_ack in IDLE produces no ack.
- rst asserted while in MEM -> all outputs 0 next cycle; the following mem_ack is ignored; a new m1 request is served normally with grant to port 0 preferred on the next tie.

Source files
------------

// File: rtl/j11bus_arb.sv
// Two-master arbiter and address decoder for the 22-bit J11 system bus.
// Routes each granted transfer to memory or the I/O page, or answers it locally with a bus error.
module j11bus_arb #(
    parameter logic [21:0] MEMTOP  = 22'h200000,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [21:0] m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic [1:0]  m0_wstrb,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [21:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic [1:0]  m1_wstrb,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic        m1_err,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,

    output logic        io_req,
    output logic        io_wr,
    output logic [12:0] io_addr,
    output logic [15:0] io_wdata,
    output logic [1:0]  io_wstrb,
    input  logic        io_ack,
    input  logic [15:0] io_rdata,
    input  logic        io_err
);

    typedef enum logic [2:0] {IDLE, MEM, IO, NXM, RESP} state_t;

    state_t      state_q, state_d;
    logic        pend0_q, pend0_d;
    logic        pend1_q, pend1_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        m0_ack_q, m0_ack_d;
    logic [15:0] m0_rdata_q, m0_rdata_d;
    logic        m0_err_q, m0_err_d;
    logic        m1_ack_q, m1_ack_d;
    logic [15:0] m1_rdata_q, m1_rdata_d;
    logic        m1_err_q, m1_err_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_wr_q, mem_wr_d;
    logic [21:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  mem_wstrb_q, mem_wstrb_d;

    logic        io_req_q, io_req_d;
    logic        io_wr_q, io_wr_d;
    logic [12:0] io_addr_q, io_addr_d;
    logic [15:0] io_wdata_q, io_wdata_d;
    logic [1:0]  io_wstrb_q, io_wstrb_d;

    logic        eff0, eff1, busy;
    logic        grantValid, grantPort;
    logic        gWr;
    logic [21:0] gAddr;
    logic [15:0] gWdata;
    logic [1:0]  gWstrb;
    logic        isIo, isMem, ioTimeout;
    logic        respValid, respErr;
    logic [15:0] respData;

    // A raw request pulse can be granted in the same cycle it arrives; ties go to the port not served last.
    always_comb begin
        eff0       = m0_req | pend0_q;
        eff1       = m1_req | pend1_q;
        busy       = (state_q != IDLE);
        grantValid = (state_q == IDLE) && (eff0 || eff1);
        grantPort  = (eff0 && eff1) ? ~last_q : eff1;
        gWr        = grantPort ? m1_wr    : m0_wr;
        gAddr      = grantPort ? m1_addr  : m0_addr;
        gWdata     = grantPort ? m1_wdata : m0_wdata;
        gWstrb     = grantPort ? m1_wstrb : m0_wstrb;
        isIo       = (gAddr[21:13] == 9'h1FF);
        isMem      = !isIo && (gAddr < MEMTOP);
    end

    assign ioTimeout = (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    if (isIo) begin
                        state_d = IO;
                    end else if (isMem) begin
                        state_d = MEM;
                    end else begin
                        state_d = NXM;
                    end
                end
            end
            MEM:     if (mem_ack) state_d = RESP;
            IO:      if (io_ack || ioTimeout) state_d = RESP;
            NXM:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Downstream fields are loaded only at grant and then held; master responses are latched on entry to RESP.
    always_comb begin
        pend0_d     = pend0_q;
        pend1_d     = pend1_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        m0_ack_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m0_err_d    = m0_err_q;
        m1_ack_d    = 1'b0;
        m1_rdata_d  = m1_rdata_q;
        m1_err_d    = m1_err_q;
        mem_req_d   = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        io_req_d    = 1'b0;
        io_wr_d     = io_wr_q;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        io_wstrb_d  = io_wstrb_q;
        respValid   = 1'b0;
        respData    = 16'h0000;
        respErr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    owner_d = grantPort;
                    last_d  = grantPort;
                    if (isIo) begin
                        io_req_d   = 1'b1;
                        io_wr_d    = gWr;
                        io_addr_d  = gAddr[12:0];
                        io_wdata_d = gWdata;
                        io_wstrb_d = gWstrb;
                        cnt_d      = 8'd0;
                    end else if (isMem) begin
                        mem_req_d   = 1'b1;
                        mem_wr_d    = gWr;
                        mem_addr_d  = gAddr;
                        mem_wdata_d = gWdata;
                        mem_wstrb_d = gWstrb;
                    end
                end
            end
            MEM: begin
                if (mem_ack) begin
                    respValid = 1'b1;
                    respData  = mem_rdata;
                end
            end
            IO: begin
                cnt_d = cnt_q + 8'd1;
                if (io_ack) begin
                    respValid = 1'b1;
                    respData  = io_rdata;
                    respErr   = io_err;
                end else if (ioTimeout) begin
                    respValid = 1'b1;
                    respErr   = 1'b1;
                end
            end
            NXM: begin
                respValid = 1'b1;
                respErr   = 1'b1;
            end
            default: ;
        endcase

        if (respValid) begin
            if (owner_q) begin
                m1_ack_d   = 1'b1;
                m1_rdata_d = respData;
                m1_err_d   = respErr;
            end else begin
                m0_ack_d   = 1'b1;
                m0_rdata_d = respData;
                m0_err_d   = respErr;
            end
        end

        // A repeat request from the port already being served is a protocol violation and is dropped.
        if (grantValid && !grantPort) begin
            pend0_d = 1'b0;
        end else if (m0_req && !(busy && !owner_q)) begin
            pend0_d = 1'b1;
        end
        if (grantValid && grantPort) begin
            pend1_d = 1'b0;
        end else if (m1_req && !(busy && owner_q)) begin
            pend1_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend0_q     <= 1'b0;
            pend1_q     <= 1'b0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            cnt_q       <= 8'd0;
            m0_ack_q    <= 1'b0;
            m0_rdata_q  <= 16'h0000;
            m0_err_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m1_rdata_q  <= 16'h0000;
            m1_err_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 22'h000000;
            mem_wdata_q <= 16'h0000;
            mem_wstrb_q <= 2'b00;
            io_req_q    <= 1'b0;
            io_wr_q     <= 1'b0;
            io_addr_q   <= 13'h0000;
            io_wdata_q  <= 16'h0000;
            io_wstrb_q  <= 2'b00;
        end else begin
            pend0_q     <= pend0_d;
            pend1_q     <= pend1_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            m0_ack_q    <= m0_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m0_err_q    <= m0_err_d;
            m1_ack_q    <= m1_ack_d;
            m1_rdata_q  <= m1_rdata_d;
            m1_err_q    <= m1_err_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            io_req_q    <= io_req_d;
            io_wr_q     <= io_wr_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
            io_wstrb_q  <= io_wstrb_d;
        end
    end

    assign m0_ack    = m0_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m0_err    = m0_err_q;
    assign m1_ack    = m1_ack_q;
    assign m1_rdata  = m1_rdata_q;
    assign m1_err    = m1_err_q;
    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign io_req    = io_req_q;
    assign io_wr     = io_wr_q;
    assign io_addr   = io_addr_q;
    assign io_wdata  = io_wdata_q;
    assign io_wstrb  = io_wstrb_q;

endmodule

// File: tb/tb_j11bus_arb.sv
// Scoreboard bench for j11bus_arb: downstream requests and master acks are matched against queued expectations.
// A single process drives stimulus, models memory/I-O responders and checks outputs on the falling edge.
module tb_j11bus_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_wr = 1'b0;
    logic [21:0] m0_addr = '0;
    logic [15:0] m0_wdata = '0;
    logic [1:0]  m0_wstrb = '0;
    logic        m0_ack, m0_err;
    logic [15:0] m0_rdata;
    logic        m1_req = 1'b0, m1_wr = 1'b0;
    logic [21:0] m1_addr = '0;
    logic [15:0] m1_wdata = '0;
    logic [1:0]  m1_wstrb = '0;
    logic        m1_ack, m1_err;
    logic [15:0] m1_rdata;
    logic        mem_req, mem_wr;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        io_req, io_wr;
    logic [12:0] io_addr;
    logic [15:0] io_wdata;
    logic [1:0]  io_wstrb;
    logic        io_ack = 1'b0, io_err = 1'b0;
    logic [15:0] io_rdata = '0;

    always #5 clk = ~clk;

    j11bus_arb #(.MEMTOP(22'h200000), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .io_req(io_req), .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
        .io_ack(io_ack), .io_rdata(io_rdata), .io_err(io_err)
    );

    typedef struct {
        int          port;
        logic [15:0] rdata;
        logic        err;
        bit          chkData;
        int          cyc;
    } resp_t;

    typedef struct {
        bit          isIo;
        logic        wr;
        logic [21:0] addr;
        logic [15:0] wdata;
        logic [1:0]  wstrb;
        int          cyc;
    } ds_t;

    resp_t       respQ[$];
    ds_t         dsQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ackCount = 0;
    int          memDelay = 1, memCnt = 0;
    int          ioDelay = 1, ioCnt = 0;
    bit          ioRespond = 1'b1;
    bit          forceIoAck = 1'b0;
    logic        ioErrVal = 1'b0;
    logic [15:0] ioDataVal = 16'h0000;
    logic [21:0] memAddrLat = '0;

    function automatic logic [15:0] memModel(logic [21:0] a);
        return a[15:0] ^ 16'h0234;
    endfunction

    task automatic checkOutput(string tag, logic [63:0] actual, logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic monitorCycle();
        resp_t r;
        ds_t   d;
        if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
            ackCount++;
            if (respQ.size() == 0) begin
                checkOutput("unexpectedAck", {m1_ack, m0_ack}, 0);
            end else begin
                r = respQ.pop_front();
                checkOutput("ackBoth", m0_ack & m1_ack, 0);
                checkOutput("ackPort", m1_ack ? 1 : 0, r.port);
                if (r.chkData) checkOutput("ackRdata", m1_ack ? m1_rdata : m0_rdata, r.rdata);
                checkOutput("ackErr", m1_ack ? m1_err : m0_err, r.err);
                checkOutput("ackCycle", cyc, r.cyc);
            end
        end
        if (mem_req === 1'b1 || io_req === 1'b1) begin
            if (dsQ.size() == 0) begin
                checkOutput("unexpectedReq", {io_req, mem_req}, 0);
            end else begin
                d = dsQ.pop_front();
                checkOutput("reqIsIo", io_req, d.isIo);
                checkOutput("reqCycle", cyc, d.cyc);
                if (io_req) begin
                    checkOutput("ioAddr", io_addr, d.addr[12:0]);
                    checkOutput("ioWr", io_wr, d.wr);
                    checkOutput("ioWdata", io_wdata, d.wdata);
                    checkOutput("ioWstrb", io_wstrb, d.wstrb);
                end else begin
                    checkOutput("memAddr", mem_addr, d.addr);
                    checkOutput("memWr", mem_wr, d.wr);
                    checkOutput("memWdata", mem_wdata, d.wdata);
                    checkOutput("memWstrb", mem_wstrb, d.wstrb);
                end
            end
        end
        // Responders: pulse an ack a fixed number of cycles after each downstream request.
        mem_ack = 1'b0;
        io_ack  = 1'b0;
        io_err  = 1'b0;
        if (mem_req === 1'b1) begin
            memCnt     = memDelay;
            memAddrLat = mem_addr;
        end else if (memCnt > 0) begin
            memCnt--;
            if (memCnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = memModel(memAddrLat);
            end
        end
        if (io_req === 1'b1) begin
            ioCnt = ioRespond ? ioDelay : 0;
        end else if (ioCnt > 0) begin
            ioCnt--;
            if (ioCnt == 0) begin
                io_ack   = 1'b1;
                io_err   = ioErrVal;
                io_rdata = ioDataVal;
            end
        end
        if (forceIoAck) begin
            io_ack     = 1'b1;
            forceIoAck = 1'b0;
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        monitorCycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic applyStimulus(int port, logic wr, logic [21:0] addr, logic [15:0] wdata, logic [1:0] wstrb);
        if (port == 0) begin
            m0_wr = wr; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_req = 1'b1;
        end else begin
            m1_wr = wr; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_req = 1'b1;
        end
    endtask

    task automatic releaseReq();
        stepCycle();
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic pushDs(bit isIo, logic wr, logic [21:0] addr, logic [15:0] wdata, logic [1:0] wstrb, int c);
        ds_t d;
        d.isIo = isIo; d.wr = wr; d.addr = addr; d.wdata = wdata; d.wstrb = wstrb; d.cyc = c;
        dsQ.push_back(d);
    endtask

    task automatic pushResp(int port, logic [15:0] rdata, logic err, bit chkData, int c);
        resp_t r;
        r.port = port; r.rdata = rdata; r.err = err; r.chkData = chkData; r.cyc = c;
        respQ.push_back(r);
    endtask

    task automatic expectMem(int port, logic wr, logic [21:0] addr, logic [15:0] wdata, logic [1:0] wstrb,
                             int reqCyc, int ackCyc);
        pushDs(1'b0, wr, addr, wdata, wstrb, reqCyc);
        pushResp(port, memModel(addr), 1'b0, !wr, ackCyc);
    endtask

    task automatic waitDone(int budget);
        int n = 0;
        while ((respQ.size() > 0 || dsQ.size() > 0) && n < budget) begin
            stepCycle();
            n++;
        end
        if (respQ.size() > 0 || dsQ.size() > 0) begin
            checkOutput("doneTimeout", respQ.size() + dsQ.size(), 0);
            respQ.delete();
            dsQ.delete();
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstMem", {mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb}, 0);
        checkOutput("rstIo", {io_req, io_wr, io_addr, io_wdata, io_wstrb}, 0);
        checkOutput("rstM0", {m0_ack, m0_err, m0_rdata}, 0);
        checkOutput("rstM1", {m1_ack, m1_err, m1_rdata}, 0);
    endtask

    task automatic tieRound(logic [21:0] a0, logic [21:0] a1);
        int c = cyc;
        memDelay = 1;
        applyStimulus(0, 1'b0, a0, 16'h0000, 2'b11);
        applyStimulus(1, 1'b0, a1, 16'h0000, 2'b11);
        expectMem(0, 1'b0, a0, 16'h0000, 2'b11, c + 1, c + 3);
        expectMem(1, 1'b0, a1, 16'h0000, 2'b11, c + 5, c + 7);
        releaseReq();
        waitDone(40);
    endtask

    initial begin
        int c;
        int ackBefore;

        rst = 1'b1;
        repeat (3) stepCycle();
        rst = 1'b0;
        checkResetOutputs();

        for (int i = 0; i < 3; i++) begin
            tieRound(22'h002000 + 22'(i * 16), 22'h003400 + 22'(i * 16));
        end

        $display("[TB] memory read with delayed ack");
        memDelay = 3;
        c = cyc;
        applyStimulus(0, 1'b0, 22'h001000, 16'h0000, 2'b11);
        expectMem(0, 1'b0, 22'h001000, 16'h0000, 2'b11, c + 1, c + 5);
        releaseReq();
        waitDone(40);

        $display("[TB] I/O page write answered with error");
        ioRespond = 1'b1; ioDelay = 2; ioErrVal = 1'b1; ioDataVal = 16'hBEEF;
        c = cyc;
        applyStimulus(0, 1'b1, 22'h3FFF70, 16'h00AA, 2'b01);
        pushDs(1'b1, 1'b1, 22'h3FFF70, 16'h00AA, 2'b01, c + 1);
        pushResp(0, 16'h0000, 1'b1, 1'b0, c + 4);
        releaseReq();
        waitDone(40);

        $display("[TB] nonexistent memory");
        c = cyc;
        applyStimulus(1, 1'b0, 22'h250000, 16'h0000, 2'b11);
        pushResp(1, 16'h0000, 1'b1, 1'b1, c + 2);
        releaseReq();
        waitDone(40);

        $display("[TB] request queued behind a busy transfer");
        memDelay = 3;
        c = cyc;
        applyStimulus(0, 1'b0, 22'h000100, 16'h0000, 2'b11);
        expectMem(0, 1'b0, 22'h000100, 16'h0000, 2'b11, c + 1, c + 5);
        releaseReq();
        stepCycle();
        applyStimulus(1, 1'b1, 22'h000200, 16'h5555, 2'b10);
        expectMem(1, 1'b1, 22'h000200, 16'h5555, 2'b10, c + 7, c + 11);
        releaseReq();
        waitDone(40);

        $display("[TB] I/O watchdog timeout");
        ioRespond = 1'b0;
        io_rdata  = 16'hDEAD;
        c = cyc;
        applyStimulus(0, 1'b0, 22'h3FE010, 16'h0000, 2'b11);
        pushDs(1'b1, 1'b0, 22'h3FE010, 16'h0000, 2'b11, c + 1);
        pushResp(0, 16'h0000, 1'b1, 1'b1, c + 65);
        releaseReq();
        waitDone(100);
        ackBefore  = ackCount;
        forceIoAck = 1'b1;
        repeat (4) stepCycle();
        checkOutput("strayIoAck", ackCount - ackBefore, 0);

        $display("[TB] reset during memory transfer");
        memDelay = 10;
        c = cyc;
        applyStimulus(0, 1'b0, 22'h004000, 16'h0000, 2'b11);
        expectMem(0, 1'b0, 22'h004000, 16'h0000, 2'b11, c + 1, c + 12);
        releaseReq();
        stepCycle();
        stepCycle();
        rst = 1'b1;
        respQ.delete();
        stepCycle();
        rst = 1'b0;
        checkResetOutputs();
        ackBefore = ackCount;
        repeat (12) stepCycle();
        checkOutput("noAckAfterRst", ackCount - ackBefore, 0);

        tieRound(22'h005000, 22'h006000);

        memDelay = 2;
        c = cyc;
        applyStimulus(1, 1'b0, 22'h000600, 16'h0000, 2'b11);
        expectMem(1, 1'b0, 22'h000600, 16'h0000, 2'b11, c + 1, c + 4);
        releaseReq();
        waitDone(40);
        repeat (2) stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
